// File: rtl/lmsm_pkg.sv
// Shared types for the LM/SM memory-stage engine: FSM state encoding,
// control fields of a queued step, and the register-index width.
package lmsm_pkg;

   localparam int REG_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } lmsm_state_t;

   // Control part of one queued step; the address travels alongside it
   // because its width is set by the engine's ADDR_W parameter.
   typedef struct packed {
      logic                 is_lm;
      logic [REG_IDX_W-1:0] reg_idx;
      logic                 last;
   } lmsm_ctl_t;

endpackage

// File: rtl/lmsm_req_fifo.sv
// Synchronous request FIFO for LM/SM steps. DEPTH must be a power of two
// so the read/write pointers wrap naturally. Push while full and pop while
// empty are ignored.
module lmsm_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];
   assign count   = count_q;

   // Storage array: written on accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; simultaneous push and pop keeps count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/lmsm_mem_engine.sv
// LM/SM memory-stage responder: queues per-register steps, performs one
// data-memory access per step, writes loaded words back to the RF and
// pulses done when the last step of a burst retires.
// Optional burst-sequence checker enabled by defining LMSM_SEQ_CHECK_EN.
//
// Handshakes: a step is accepted when req_valid & req_ready in the same
// cycle; req_ready depends only on queue fullness. A memory access is
// accepted when dm_req & dm_gnt in the same cycle; until then dm_req and
// its address/data/we stay stable. dm_rvalid is honoured only in WAIT_RD.
module lmsm_mem_engine
   import lmsm_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_is_lm,
   input  logic [2:0]           req_reg,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic                 req_last,
   output logic [2:0]           rf_rd_addr,
   input  logic [DATA_W-1:0]    rf_rd_data,
   output logic                 dm_req,
   output logic                 dm_we,
   output logic [ADDR_W-1:0]    dm_addr,
   output logic [DATA_W-1:0]    dm_wdata,
   input  logic                 dm_gnt,
   input  logic                 dm_rvalid,
   input  logic [DATA_W-1:0]    dm_rdata,
   output logic                 rf_we,
   output logic [2:0]           rf_wa,
   output logic [DATA_W-1:0]    rf_wd,
   output logic                 busy,
   output logic                 done,
   output logic                 seq_err,
   output logic [1:0]           fsm_state
);

   localparam int ENT_W = $bits(lmsm_ctl_t) + ADDR_W;
   localparam int CNT_W = $clog2(DEPTH+1);

   lmsm_state_t       state_q, state_d;
   lmsm_ctl_t         in_ctl, head_ctl;
   logic [ADDR_W-1:0] head_addr;
   logic [ENT_W-1:0]  head_ent;
   logic [CNT_W-1:0]  count;
   logic              full, empty, push, pop;
   logic              grant_sm, rd_ret, more;

   assign req_ready = ~full;
   assign push      = req_valid & req_ready;
   assign in_ctl    = '{is_lm: req_is_lm, reg_idx: req_reg, last: req_last};
   assign {head_ctl, head_addr} = head_ent;

   lmsm_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({in_ctl, req_addr}),
      .pop   (pop),
      .head  (head_ent),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A step retires on an SM grant or on LM read data; a push in the same
   // cycle counts as "another entry remains" since it is issued next cycle.
   assign grant_sm = (state_q == ISSUE) & dm_gnt & ~head_ctl.is_lm;
   assign rd_ret   = (state_q == WAIT_RD) & dm_rvalid;
   assign pop      = grant_sm | rd_ret;
   assign more     = (count > CNT_W'(1)) | push;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (~empty | push) state_d = ISSUE;
         ISSUE:   if (dm_gnt) begin
                     if (head_ctl.is_lm) state_d = WAIT_RD;
                     else                state_d = more ? ISSUE : IDLE;
                  end
         WAIT_RD: if (dm_rvalid) state_d = more ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory request and RF read port; quiet outside ISSUE.
   always_comb begin
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      dm_addr    = '0;
      dm_wdata   = '0;
      rf_rd_addr = '0;
      if (state_q == ISSUE) begin
         dm_req     = 1'b1;
         dm_we      = ~head_ctl.is_lm;
         dm_addr    = head_addr;
         rf_rd_addr = head_ctl.reg_idx;
         dm_wdata   = rf_rd_data;
      end
   end

   // Registered writeback and done pulse; data fields are zero when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
         done  <= 1'b0;
      end else begin
         rf_we <= rd_ret;
         rf_wa <= rd_ret ? head_ctl.reg_idx : '0;
         rf_wd <= rd_ret ? dm_rdata : '0;
         done  <= pop & head_ctl.last;
      end
   end

   assign busy      = (count != '0) | (state_q != IDLE) | rf_we | done;
   assign fsm_state = state_q;

`ifdef LMSM_SEQ_CHECK_EN
   logic              trk_valid;
   logic              prev_lm;
   logic [2:0]        prev_reg;
   logic [ADDR_W-1:0] prev_addr;
   logic              seq_err_q;
   logic              step_bad;

   // A step is bad if it breaks address/register/direction continuity.
   always_comb begin
      step_bad = trk_valid & ((req_addr != prev_addr + ADDR_W'(1)) |
                              (req_reg <= prev_reg) |
                              (req_is_lm != prev_lm));
   end

   // Burst tracker; forgets history after the last step, error is sticky.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_valid <= 1'b0;
         prev_lm   <= 1'b0;
         prev_reg  <= '0;
         prev_addr <= '0;
         seq_err_q <= 1'b0;
      end else if (push) begin
         if (step_bad) seq_err_q <= 1'b1;
         trk_valid <= ~req_last;
         prev_lm   <= req_is_lm;
         prev_reg  <= req_reg;
         prev_addr <= req_addr;
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_lmsm_mem_engine.sv
// Directed bench for lmsm_mem_engine: cycle tables for the SM and LM
// bursts, plus sequences for full queue, reset mid-LM and the checker.
module tb_lmsm_mem_engine;
   import lmsm_pkg::*;

`ifdef LMSM_SEQ_CHECK_EN
   localparam logic EXP_SEQ_ERR = 1'b1;
`else
   localparam logic EXP_SEQ_ERR = 1'b0;
`endif

   logic        clk, rst;
   logic        req_valid, req_ready, req_is_lm, req_last;
   logic [2:0]  req_reg, rf_rd_addr, rf_wa;
   logic [15:0] req_addr, rf_rd_data, dm_addr, dm_wdata, dm_rdata, rf_wd;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid, rf_we, busy, done, seq_err;
   logic [1:0]  fsm_state;

   int n_chk  = 0;
   int n_fail = 0;

   lmsm_mem_engine #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_lm(req_is_lm),
      .req_reg(req_reg), .req_addr(req_addr), .req_last(req_last),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .busy(busy), .done(done), .seq_err(seq_err), .fsm_state(fsm_state)
   );

   // Register file model: Rn reads as 0x1000 + n.
   always_comb rf_rd_data = 16'h1000 + {13'd0, rf_rd_addr};

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        v, lm;
      logic [2:0]  rg;
      logic [15:0] addr;
      logic        last, gnt, rv;
      logic [15:0] rdata;
      logic [5:0]  e_flags;  // ready, dm_req, dm_we, rf_we, done, busy
      logic [15:0] e_addr, e_wdata;
      logic [2:0]  e_wa;
      logic [15:0] e_wd;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(logic v, logic lm, logic [2:0] rg, logic [15:0] a,
                               logic last, logic g, logic rv, logic [15:0] rd,
                               logic [5:0] f, logic [15:0] ea, logic [15:0] ew,
                               logic [2:0] wa, logic [15:0] wd);
      vec_t r;
      r.v = v; r.lm = lm; r.rg = rg; r.addr = a; r.last = last; r.gnt = g;
      r.rv = rv; r.rdata = rd; r.e_flags = f; r.e_addr = ea; r.e_wdata = ew;
      r.e_wa = wa; r.e_wd = wd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_is_lm = 1'b0; req_reg = '0; req_addr = '0;
      req_last = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_flags"}, {req_ready, dm_req, dm_we, rf_we, done, busy, seq_err}, 7'b1000000);
      chk({tag, "_data"}, {dm_addr, dm_wdata, rf_wd}, 48'h0);
      chk({tag, "_idx"}, {rf_wa, rf_rd_addr}, 6'h0);
      chk({tag, "_state"}, fsm_state, IDLE);
   endtask

   // Asserts reset for two cycles, checks, releases just after an edge.
   task automatic do_reset(input string tag);
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs(tag);
      rst = 1'b0;
   endtask

   // Applies table rows lo..hi, one per cycle, starting just after an edge.
   task automatic run_rows(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) begin
         req_valid = tbl[i].v; req_is_lm = tbl[i].lm; req_reg = tbl[i].rg;
         req_addr = tbl[i].addr; req_last = tbl[i].last; dm_gnt = tbl[i].gnt;
         dm_rvalid = tbl[i].rv; dm_rdata = tbl[i].rdata;
         #1;
         chk($sformatf("%s[%0d].flags", tag, i - lo),
             {req_ready, dm_req, dm_we, rf_we, done, busy}, tbl[i].e_flags);
         chk($sformatf("%s[%0d].dm_addr", tag, i - lo), dm_addr, tbl[i].e_addr);
         chk($sformatf("%s[%0d].dm_wdata", tag, i - lo), dm_wdata, tbl[i].e_wdata);
         chk($sformatf("%s[%0d].rf_wr", tag, i - lo), {rf_wa, rf_wd}, {tbl[i].e_wa, tbl[i].e_wd});
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   // Scoreboard for the full-queue drain.
   logic [15:0] exp_q[$];

   initial begin
      // SM burst R1,R3,R6 @0x40..0x42, grant always high.
      tbl[0]  = mk(1,0,3'd1,16'h0040,0, 1,0,16'h0, 6'b100000, 16'h0000,16'h0000, 3'd0,16'h0);
      tbl[1]  = mk(1,0,3'd3,16'h0041,0, 1,0,16'h0, 6'b111001, 16'h0040,16'h1001, 3'd0,16'h0);
      tbl[2]  = mk(1,0,3'd6,16'h0042,1, 1,0,16'h0, 6'b111001, 16'h0041,16'h1003, 3'd0,16'h0);
      tbl[3]  = mk(0,0,3'd0,16'h0000,0, 1,0,16'h0, 6'b111001, 16'h0042,16'h1006, 3'd0,16'h0);
      tbl[4]  = mk(0,0,3'd0,16'h0000,0, 1,0,16'h0, 6'b100011, 16'h0000,16'h0000, 3'd0,16'h0);
      tbl[5]  = mk(0,0,3'd0,16'h0000,0, 1,0,16'h0, 6'b100000, 16'h0000,16'h0000, 3'd0,16'h0);
      // LM burst R0@0xFFFF, R7@0x0000, grant two cycles late, stray rvalid ignored.
      tbl[6]  = mk(1,1,3'd0,16'hFFFF,0, 0,0,16'h0,    6'b100000, 16'h0000,16'h0000, 3'd0,16'h0);
      tbl[7]  = mk(1,1,3'd7,16'h0000,1, 0,0,16'h0,    6'b110001, 16'hFFFF,16'h1000, 3'd0,16'h0);
      tbl[8]  = mk(0,0,3'd0,16'h0000,0, 0,1,16'h1234, 6'b110001, 16'hFFFF,16'h1000, 3'd0,16'h0);
      tbl[9]  = mk(0,0,3'd0,16'h0000,0, 1,0,16'h0,    6'b110001, 16'hFFFF,16'h1000, 3'd0,16'h0);
      tbl[10] = mk(0,0,3'd0,16'h0000,0, 0,1,16'hAAAA, 6'b100001, 16'h0000,16'h0000, 3'd0,16'h0);
      tbl[11] = mk(0,0,3'd0,16'h0000,0, 0,1,16'h1234, 6'b110101, 16'h0000,16'h1007, 3'd0,16'hAAAA);
      tbl[12] = mk(0,0,3'd0,16'h0000,0, 0,0,16'h0,    6'b110001, 16'h0000,16'h1007, 3'd0,16'h0);
      tbl[13] = mk(0,0,3'd0,16'h0000,0, 1,0,16'h0,    6'b110001, 16'h0000,16'h1007, 3'd0,16'h0);
      tbl[14] = mk(0,0,3'd0,16'h0000,0, 0,1,16'h5555, 6'b100001, 16'h0000,16'h0000, 3'd0,16'h0);
      tbl[15] = mk(0,0,3'd0,16'h0000,0, 0,0,16'h0,    6'b100111, 16'h0000,16'h0000, 3'd7,16'h5555);
      tbl[16] = mk(0,0,3'd0,16'h0000,0, 0,0,16'h0,    6'b100000, 16'h0000,16'h0000, 3'd0,16'h0);

      do_reset("reset0");
      run_rows(0, 5, "sm");
      run_rows(6, 16, "lm");
      chk("seq_err_after_bursts", seq_err, 1'b0);

      // Full queue: five SM steps with grant low, then drain.
      begin
         int pushed, got, done_cnt;
         logic ready_back;
         pushed = 0; got = 0; done_cnt = 0; ready_back = 1'b0;
         for (int c = 0; c < 8; c++) begin
            req_valid = (pushed < 5); req_is_lm = 1'b0; req_reg = 3'(pushed + 1);
            req_addr = 16'(16'h0100 + pushed); req_last = (pushed == 4); dm_gnt = 1'b0;
            #1;
            if (c == 4) chk("full_ready_low", req_ready, 1'b0);
            if (c == 7) chk("full_hold", {req_ready, dm_req, dm_addr}, {2'b01, 16'h0100});
            if (req_valid && req_ready) begin exp_q.push_back(req_addr); pushed++; end
            @(posedge clk); #1;
         end
         chk("full_pushed_before_gnt", pushed, 4);
         dm_gnt = 1'b1;
         for (int c = 0; c < 40 && (got < 5 || busy); c++) begin
            req_valid = (pushed < 5); req_reg = 3'(pushed + 1);
            req_addr = 16'(16'h0100 + pushed); req_last = (pushed == 4);
            #1;
            if (dm_req && dm_gnt) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL drain_extra: unexpected access at %h", dm_addr);
               end else begin
                  chk("drain_order", dm_addr, exp_q.pop_front());
               end
               got++;
            end
            if (done) done_cnt++;
            if (req_ready && pushed == 4) ready_back = 1'b1;
            if (req_valid && req_ready) begin exp_q.push_back(req_addr); pushed++; end
            @(posedge clk); #1;
         end
         idle_inputs();
         chk("drain_ready_back", ready_back, 1'b1);
         chk("drain_count", got, 5);
         chk("drain_done_once", done_cnt, 1);
         chk("drain_queue_empty", exp_q.size(), 0);
         chk("drain_idle", {busy, req_ready}, 2'b01);
      end
      chk("seq_err_after_drain", seq_err, 1'b0);

      // Reset while waiting for LM read data; a late rvalid must be ignored.
      req_valid = 1'b1; req_is_lm = 1'b1; req_reg = 3'd2; req_addr = 16'h0020;
      req_last = 1'b1; dm_gnt = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("midlm_wait_rd", {fsm_state, busy}, {WAIT_RD, 1'b1});
      rst = 1'b1;
      #1;
      idle_inputs();
      #1;
      check_reset_outputs("midlm_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      dm_rvalid = 1'b1; dm_rdata = 16'hBEEF;
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
      #1;
      chk("late_rvalid_ignored", {rf_we, rf_wd, busy}, 18'h0);
      chk("late_rvalid_state", fsm_state, IDLE);

      // Checker: SM steps at 0x0010 then 0x0012 (address gap).
      dm_gnt = 1'b1;
      req_valid = 1'b1; req_is_lm = 1'b0; req_reg = 3'd1; req_addr = 16'h0010; req_last = 1'b0;
      @(posedge clk); #1;
      req_reg = 3'd2; req_addr = 16'h0012; req_last = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("seq_err_set", seq_err, EXP_SEQ_ERR);
      repeat (5) @(posedge clk);
      #1;
      chk("seq_err_sticky", {seq_err, busy}, {EXP_SEQ_ERR, 1'b0});
      do_reset("reset_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
